pp_adder_tree_pipe: RTL

Parametrised, pipelined reduction tree that sums N_PP partial products of W bits into one W-bit product, with one register stage per tree level and valid/ready flow control. Successor to the fixed 8×64 single-cycle tree in the Booth multiplier datapath: it sits between the Booth partial-product generator and the multiplier result register. It supports backpressure, bubble collapsing, a sideband tag, and optional overflow reporting.

---
 rtl/adder_tree_pkg.sv | 24 ++
 rtl/adder_tree_level.sv | 91 +++++++++
 rtl/pp_adder_tree_pipe.sv | 89 ++++++++
 3 files changed

// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined partial-product adder tree.
// Optional overflow reporting is enabled with ADDER_TREE_OVF_EN.
package adder_tree_pkg;

    // Number of pairwise reduction levels needed for n inputs (ceil(log2(n))).
    function automatic int unsigned tree_levels(input int unsigned n);
        int unsigned l;
        l = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) l = i + 1;
        end
        return l;
    endfunction

    // Number of values registered by level k.
    function automatic int unsigned stage_width(input int unsigned n_pp, input int unsigned k);
        return n_pp >> (k + 1);
    endfunction

    function automatic bit pp_count_ok(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One reduction level: pairwise W-bit wrapping adds, registered with valid, tag
// and (with ADDER_TREE_OVF_EN) a sticky signed-overflow bit.
module adder_tree_level #(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned W     = 64,
    parameter int unsigned TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [N_IN*W-1:0]       in_data,
    input  logic [TAG_W-1:0]        in_tag,
`ifdef ADDER_TREE_OVF_EN
    input  logic                    in_ovf,
`endif
    input  logic                    adv_next,
    output logic                    adv,
    output logic                    out_valid,
    output logic [(N_IN/2)*W-1:0]   out_data,
    output logic [TAG_W-1:0]        out_tag
`ifdef ADDER_TREE_OVF_EN
    ,
    output logic                    out_ovf
`endif
);

    localparam int unsigned N_OUT = N_IN / 2;

    logic [N_OUT*W-1:0] sums;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic [W-1:0]       s;
    logic [N_OUT*W-1:0] data_q;
    logic [TAG_W-1:0]   tag_q;
    logic               valid_q;
`ifdef ADDER_TREE_OVF_EN
    logic               ovf_add;
    logic               ovf_q;
`endif

    always_comb begin
        sums = '0;
        a    = '0;
        b    = '0;
        s    = '0;
`ifdef ADDER_TREE_OVF_EN
        ovf_add = in_ovf;
`endif
        for (int unsigned j = 0; j < N_OUT; j++) begin
            a = in_data[(2*j)*W +: W];
            b = in_data[(2*j+1)*W +: W];
            s = a + b;
            sums[j*W +: W] = s;
`ifdef ADDER_TREE_OVF_EN
            // Signed overflow: same operand signs, different result sign.
            ovf_add = ovf_add | ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1]));
`endif
        end
    end

    // Load when empty or when the current contents move downstream this cycle.
    assign adv = !valid_q || adv_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
`ifdef ADDER_TREE_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (adv) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= sums;
                tag_q  <= in_tag;
`ifdef ADDER_TREE_OVF_EN
                ovf_q  <= ovf_add;
`endif
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_tag   = tag_q;
`ifdef ADDER_TREE_OVF_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: rtl/pp_adder_tree_pipe.sv
// Pipelined N_PP-input modulo-2^W adder tree with valid/ready flow control and a
// sideband tag. Define ADDER_TREE_OVF_EN to add the out_ovf signed-overflow port.
module pp_adder_tree_pipe
    import adder_tree_pkg::*;
#(
    parameter int unsigned N_PP  = 8,
    parameter int unsigned W     = 64,
    parameter int unsigned TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_PP*W-1:0]   in_pp,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_sum,
    output logic [TAG_W-1:0]    out_tag
`ifdef ADDER_TREE_OVF_EN
    ,
    output logic                out_ovf
`endif
);

    localparam int unsigned LEVELS = tree_levels(N_PP);

    if (!pp_count_ok(N_PP)) begin : g_bad_npp
        $error("pp_adder_tree_pipe: N_PP must be a power of two and >= 2");
    end

    logic [LEVELS:0]  adv;
    logic [LEVELS:0]  vchain;
    logic [TAG_W-1:0] tchain [0:LEVELS];
`ifdef ADDER_TREE_OVF_EN
    logic [LEVELS:0]  ochain;
    assign ochain[0] = 1'b0;
    assign out_ovf   = ochain[LEVELS];
`endif

    assign adv[LEVELS] = out_ready;
    assign in_ready    = adv[0];
    assign vchain[0]   = in_valid;
    assign tchain[0]   = in_tag;
    assign out_valid   = vchain[LEVELS];
    assign out_tag     = tchain[LEVELS];

    for (genvar k = 0; k < LEVELS; k++) begin : lvl
        localparam int unsigned NI = N_PP >> k;

        logic [NI*W-1:0]                          din;
        logic [stage_width(N_PP, k)*W-1:0]        q;

        if (k == 0) begin : g_first
            assign din = in_pp;
        end else begin : g_rest
            assign din = lvl[k-1].q;
        end

        adder_tree_level #(
            .N_IN  (NI),
            .W     (W),
            .TAG_W (TAG_W)
        ) u_level (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vchain[k]),
            .in_data   (din),
            .in_tag    (tchain[k]),
`ifdef ADDER_TREE_OVF_EN
            .in_ovf    (ochain[k]),
`endif
            .adv_next  (adv[k+1]),
            .adv       (adv[k]),
            .out_valid (vchain[k+1]),
            .out_data  (q),
            .out_tag   (tchain[k+1])
`ifdef ADDER_TREE_OVF_EN
            ,
            .out_ovf   (ochain[k+1])
`endif
        );

        if (k == LEVELS - 1) begin : g_last
            assign out_sum = q;
        end
    end

endmodule
